// File: rtl/aes_inv_pkg.sv
// Shared FSM type, block geometry and GF(2^8) helpers for the AES inverse round engine.
// A block holds 16 bytes; byte i sits at bits [8i +: 8] with row = i % 4 and column = i / 4.
package aes_inv_pkg;

    localparam int NB      = 4;
    localparam int BLOCK_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } fsm_state_e;

    // Row r is rotated right by r columns: out(r,c) = in(r,(c-r) mod 4).
    function automatic logic [0:BLOCK_W-1] inv_shift_rows(input logic [0:BLOCK_W-1] s);
        logic [0:BLOCK_W-1] o;
        o = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(r + 4*c) +: 8] = s[8*(r + 4*((c - r + NB) % NB)) +: 8];
            end
        end
        return o;
    endfunction

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by one of the InvMixColumns coefficients, built from repeated xtime.
    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [7:0] c);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        logic [7:0] r;
        x2 = gf_mul2(b);
        x4 = gf_mul2(x2);
        x8 = gf_mul2(x4);
        case (c)
            8'h09:   r = x8 ^ b;
            8'h0b:   r = x8 ^ x2 ^ b;
            8'h0d:   r = x8 ^ x4 ^ b;
            8'h0e:   r = x8 ^ x4 ^ x2;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // One column times the circulant matrix [0e 0b 0d 09]; bits [31:24] carry row 0.
    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        {a0, a1, a2, a3} = col;
        return { gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                 gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                 gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                 gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e) };
    endfunction

    // Apply the column transform to all four columns of the block.
    function automatic logic [0:BLOCK_W-1] inv_mix_columns(input logic [0:BLOCK_W-1] s);
        logic [0:BLOCK_W-1] o;
        o = '0;
        for (int c = 0; c < NB; c++) begin
            o[32*c +: 32] = inv_mix_column(s[32*c +: 32]);
        end
        return o;
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational FIPS-197 inverse S-box, one byte in, one byte out.
module inv_sbox (
    input  logic [7:0] in_byte_i,
    output logic [7:0] out_byte_o
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Plain table lookup.
    always_comb begin
        out_byte_o = INV_SBOX[in_byte_i];
    end

endmodule

// File: rtl/aes_inv_round_engine.sv
// Iterative AES inverse cipher: one round per clock, round keys fetched by index
// from an external key store, valid/ready on both the ciphertext and plaintext sides.
// Optional status outputs (busy, dbg_round) are enabled by defining AES_INV_ROUND_STATUS_EN.
module aes_inv_round_engine
    import aes_inv_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [0:BLOCK_W-1] in_block,
    output logic [3:0]         rk_round,
    input  logic [0:BLOCK_W-1] rk_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [0:BLOCK_W-1] out_block
`ifdef AES_INV_ROUND_STATUS_EN
    ,
    output logic               busy,
    output logic [3:0]         dbg_round
`endif
);

    localparam logic [3:0] NR_L = 4'(NR);

    if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
        $error("aes_inv_round_engine: NR must be 10, 12 or 14");
    end

    fsm_state_e         fsm_q;
    fsm_state_e         fsm_d;
    logic [0:BLOCK_W-1] state_q;
    logic [0:BLOCK_W-1] state_d;
    logic [3:0]         cnt_q;
    logic [3:0]         cnt_d;

    logic [0:BLOCK_W-1] shifted;
    logic [0:BLOCK_W-1] subbed;
    logic [0:BLOCK_W-1] keyed;
    logic [0:BLOCK_W-1] mixed;

    // Round datapath: the final round simply skips the mix stage.
    assign shifted = inv_shift_rows(state_q);

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        inv_sbox u_inv_sbox (
            .in_byte_i  (shifted[8*i +: 8]),
            .out_byte_o (subbed[8*i +: 8])
        );
    end

    assign keyed     = subbed ^ rk_data;
    assign mixed     = inv_mix_columns(keyed);
    assign out_block = state_q;

    // Register FSM, cipher state and round counter; reset abandons any block in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            cnt_q   <= NR_L;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, key index and handshake outputs; the key index walks NR down to 0.
    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        rk_round  = 4'd0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                in_ready = rst_n;
                rk_round = NR_L;
                if (in_valid) begin
                    state_d = in_block ^ rk_data;
                    cnt_d   = NR_L - 4'd1;
                    fsm_d   = ST_ROUND;
                end
            end
            ST_ROUND: begin
                rk_round = cnt_q;
                state_d  = mixed;
                cnt_d    = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    fsm_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                rk_round = 4'd0;
                state_d  = keyed;
                fsm_d    = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

`ifdef AES_INV_ROUND_STATUS_EN
    // Status view: busy whenever a block is owned, dbg_round mirrors the live round counter.
    always_comb begin
        busy      = 1'b0;
        dbg_round = 4'd0;
        if (rst_n) begin
            busy      = (fsm_q != ST_IDLE);
            dbg_round = (fsm_q == ST_ROUND || fsm_q == ST_FINAL) ? cnt_q : NR_L;
        end
    end
`endif

endmodule

// File: tb/tb_aes_inv_round_engine.sv
// Self-checking bench for aes_inv_round_engine (NR=10 and NR=14 instances).
// Random traffic is checked against a forward AES model: random plaintext is
// encrypted in the bench and the engine must recover it.
module tb_aes_inv_round_engine;

    localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C3_CT   = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic clk = 1'b0;
    logic rstN;

    logic         inValid10, inReady10, outValid10, outReady10;
    logic [0:127] inBlock10, rkData10, outBlock10;
    logic [3:0]   rkRound10;
    logic         inValid14, inReady14, outValid14, outReady14;
    logic [0:127] inBlock14, rkData14, outBlock14;
    logic [3:0]   rkRound14;
`ifdef AES_INV_ROUND_STATUS_EN
    logic         busy10, busy14;
    logic [3:0]   dbgRound10, dbgRound14;
`endif

    logic [7:0]   sboxTab [0:255];
    logic [31:0]  w [0:59];
    logic [127:0] rk10 [0:15];
    logic [127:0] rk14 [0:15];

    int errorCount = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    assign rkData10 = rk10[rkRound10];
    assign rkData14 = rk14[rkRound14];

    aes_inv_round_engine #(.NR(10)) dut10 (
        .clk       (clk),
        .rst_n     (rstN),
        .in_valid  (inValid10),
        .in_ready  (inReady10),
        .in_block  (inBlock10),
        .rk_round  (rkRound10),
        .rk_data   (rkData10),
        .out_valid (outValid10),
        .out_ready (outReady10),
        .out_block (outBlock10)
`ifdef AES_INV_ROUND_STATUS_EN
        ,
        .busy      (busy10),
        .dbg_round (dbgRound10)
`endif
    );

    aes_inv_round_engine #(.NR(14)) dut14 (
        .clk       (clk),
        .rst_n     (rstN),
        .in_valid  (inValid14),
        .in_ready  (inReady14),
        .in_block  (inBlock14),
        .rk_round  (rkRound14),
        .rk_data   (rkData14),
        .out_valid (outValid14),
        .out_ready (outReady14),
        .out_block (outBlock14)
`ifdef AES_INV_ROUND_STATUS_EN
        ,
        .busy      (busy14),
        .dbg_round (dbgRound14)
`endif
    );

    // GF(2^8) product by shift-and-add.
    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // Forward S-box from its definition: multiplicative inverse then affine map.
    task automatic buildSbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] r;
            logic [7:0] s;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gfMul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            r = inv;
            s = inv;
            for (int k = 0; k < 4; k++) begin
                r = {r[6:0], r[7]};
                s = s ^ r;
            end
            sboxTab[x] = s ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subWord(input logic [31:0] v);
        return {sboxTab[v[31:24]], sboxTab[v[23:16]], sboxTab[v[15:8]], sboxTab[v[7:0]]};
    endfunction

    // Standard key expansion into w[]; key words are taken from the top of the 256-bit argument.
    task automatic expandKey(input logic [255:0] key, input int nk, input int nr);
        logic [7:0]  rc = 8'h01;
        logic [31:0] temp;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w[i] = key[255 - 32*i -: 32];
            end else begin
                temp = w[i-1];
                if (i % nk == 0) begin
                    temp = subWord({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
                    rc   = gfMul(rc, 8'h02);
                end else if (nk > 6 && i % nk == 4) begin
                    temp = subWord(temp);
                end
                w[i] = w[i-nk] ^ temp;
            end
        end
    endtask

    // AES-128 forward cipher using the rk10 schedule.
    function automatic logic [127:0] encrypt10(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk10[0][127-8*i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sboxTab[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r + 4*c] = t[r + 4*((c + r) % 4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    t[4*c]   = gfMul(s[4*c], 8'h02) ^ gfMul(s[4*c+1], 8'h03) ^ s[4*c+2] ^ s[4*c+3];
                    t[4*c+1] = s[4*c] ^ gfMul(s[4*c+1], 8'h02) ^ gfMul(s[4*c+2], 8'h03) ^ s[4*c+3];
                    t[4*c+2] = s[4*c] ^ s[4*c+1] ^ gfMul(s[4*c+2], 8'h02) ^ gfMul(s[4*c+3], 8'h03);
                    t[4*c+3] = gfMul(s[4*c], 8'h03) ^ s[4*c+1] ^ s[4*c+2] ^ gfMul(s[4*c+3], 8'h02);
                end
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk10[rnd][127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
        end
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Present a ciphertext to the NR=10 engine and complete the input handshake.
    task automatic applyStimulus(input logic [127:0] block);
        int n = 0;
        inBlock10 = block;
        inValid10 = 1'b1;
        while (!inReady10 && n < 60) begin
            stepClock();
            n++;
        end
        checkOutput("inputAccepted", 128'(inReady10), 128'(1));
        stepClock();
        inValid10 = 1'b0;
    endtask

    // Wait (bounded) for the NR=10 engine to present a result.
    task automatic waitOutput(input string tag);
        int n = 0;
        while (!outValid10 && n < 60) begin
            stepClock();
            n++;
        end
        checkOutput({tag, "Seen"}, 128'(outValid10), 128'(1));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] pts [3];
        logic [127:0] cts [3];
        int           hsCyc [3];
        int           edges;
        int           cyc;
        int           hsIdx;
        int           outIdx;
        logic         sawValid;

        buildSbox();
        expandKey(KEY128, 4, 10);
        for (int r = 0; r <= 10; r++) rk10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        expandKey(KEY256, 8, 14);
        for (int r = 0; r <= 14; r++) rk14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

        rstN       = 1'b0;
        inValid10  = 1'b0;
        inBlock10  = '0;
        outReady10 = 1'b0;
        inValid14  = 1'b0;
        inBlock14  = '0;
        outReady14 = 1'b1;
        stepClock();
        stepClock();

        checkOutput("resetInReady", 128'(inReady10), 128'(0));
        checkOutput("resetOutValid", 128'(outValid10), 128'(0));
        checkOutput("resetOutBlock", outBlock10, 128'(0));
        checkOutput("resetRkRound", 128'(rkRound10), 128'(10));
        rstN = 1'b1;
        stepClock();
        checkOutput("idleInReady", 128'(inReady10), 128'(1));

        // FIPS-197 C.3 on the 14-round instance.
        inBlock14 = C3_CT;
        inValid14 = 1'b1;
        checkOutput("c3Ready", 128'(inReady14), 128'(1));
        stepClock();
        inValid14 = 1'b0;
        edges = 0;
        while (!outValid14 && edges < 60) begin
            stepClock();
            edges++;
        end
        checkOutput("c3Latency", 128'(edges), 128'(14));
        checkOutput("c3Plain", outBlock14, PT_FIPS);

        // FIPS-197 C.1 with the key-index walk observed every cycle.
        inBlock10 = C1_CT;
        inValid10 = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            checkOutput($sformatf("rkRound%0d", k), 128'(rkRound10), 128'(10 - k));
            if (k > 0) checkOutput($sformatf("midRound%0d", k), 128'({outValid10, inReady10}), 128'(0));
            stepClock();
            inValid10 = 1'b0;
        end
        checkOutput("c1OutValid", 128'(outValid10), 128'(1));
        checkOutput("c1Plain", outBlock10, PT_FIPS);

        // Backpressure: result must hold while the consumer stalls.
        for (int k = 0; k < 5; k++) begin
            stepClock();
            checkOutput($sformatf("stallFlags%0d", k), 128'({outValid10, inReady10}), 128'(2'b10));
            checkOutput($sformatf("stallBlock%0d", k), outBlock10, PT_FIPS);
        end
        outReady10 = 1'b1;
        stepClock();
        checkOutput("releaseFlags", 128'({outValid10, inReady10}), 128'(2'b01));

        // A second block offered mid-decryption must be ignored.
        applyStimulus(C1_CT);
        stepClock();
        stepClock();
        inBlock10 = {$urandom, $urandom, $urandom, $urandom};
        inValid10 = 1'b1;
        stepClock();
        stepClock();
        inValid10 = 1'b0;
        waitOutput("ignore");
        checkOutput("ignorePlain", outBlock10, PT_FIPS);
        stepClock();

        // Reset while the key index sits at round 5.
        applyStimulus(C1_CT);
        for (int k = 0; k < 4; k++) stepClock();
        checkOutput("abortAtRound5", 128'(rkRound10), 128'(5));
        rstN = 1'b0;
        stepClock();
        rstN = 1'b1;
        #1;
        checkOutput("abortFlags", 128'({outValid10, inReady10}), 128'(2'b01));
        checkOutput("abortBlock", outBlock10, 128'(0));
        sawValid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            stepClock();
            sawValid = sawValid | outValid10;
        end
        checkOutput("abortNoOutput", 128'(sawValid), 128'(0));
        applyStimulus(C1_CT);
        waitOutput("afterAbort");
        checkOutput("afterAbortPlain", outBlock10, PT_FIPS);
        stepClock();

        // Back-to-back random blocks under a random key, in_valid held high.
        expandKey({$urandom, $urandom, $urandom, $urandom, 128'h0}, 4, 10);
        for (int r = 0; r <= 10; r++) rk10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        for (int i = 0; i < 3; i++) begin
            pts[i] = {$urandom, $urandom, $urandom, $urandom};
            cts[i] = encrypt10(pts[i]);
        end
        cyc       = 0;
        hsIdx     = 0;
        outIdx    = 0;
        hsCyc     = '{0, 0, 0};
        inBlock10 = cts[0];
        inValid10 = 1'b1;
        while (outIdx < 3 && cyc < 200) begin
            if (inValid10 && inReady10) begin
                hsCyc[hsIdx] = cyc;
                hsIdx++;
            end
            if (outValid10 && outReady10) begin
                checkOutput($sformatf("b2bPlain%0d", outIdx), outBlock10, pts[outIdx]);
                outIdx++;
            end
            stepClock();
            cyc++;
            if (hsIdx < 3) inBlock10 = cts[hsIdx];
            else           inValid10 = 1'b0;
        end
        inValid10 = 1'b0;
        checkOutput("b2bAllOut", 128'(outIdx), 128'(3));
        // Handshake edges are NR+2 apart: NR+1 cycles pass between consecutive acceptances.
        checkOutput("b2bSpacing01", 128'(hsCyc[1] - hsCyc[0]), 128'(12));
        checkOutput("b2bSpacing12", 128'(hsCyc[2] - hsCyc[1]), 128'(12));

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
